branch_predictor_gshare: RTL
============================

Name: branch_predictor_gshare

Overview:
Parametrised successor to the fixed 16-entry 2-bit bimodal predictor. It holds a table of N-bit saturating counters, indexed either by PC bits alone (bimodal) or by PC XOR global history (gshare). Speculative and architected global history registers are kept, and misprediction recovery is included. The block sits beside fetch, gives a same-cycle direction prediction, and is trained from execute using the index carried down the pipeline.

Parameters:
IDX_BITS, 6, log2 of table entries; table depth = 2**IDX_BITS; legal range 2..12.
CTR_BITS, 2, width of each saturating counter; legal range 1..4.
GHR_BITS, 6, global history length; must be <= IDX_BITS.
USE_GSHARE, 1, 1 = index is PC XOR GHR; 0 = index is PC only (GHR is still maintained).

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset.
ready_o  out  1  high once table initialisation is complete.
if_valid_i  in  1  fetch presents a branch lookup this cycle.
if_pc_i  in  32  fetch PC.
pred_taken_o  out  1  predicted direction, combinational from the current state.
pred_idx_o  out  IDX_BITS  table index used for this prediction; fetch carries it to execute.
ex_valid_i  in  1  a resolved conditional branch is in execute.
ex_idx_i  in  IDX_BITS  pred_idx_o value captured when that branch was fetched.
ex_taken_i  in  1  actual branch outcome.
ex_mispredict_i  in  1  execute detected a direction mispredict; qualified by ex_valid_i.

Behaviour:
- Constants: WNT = 2**(CTR_BITS-1)-1 (weakly not-taken). MAX = 2**CTR_BITS-1.
- Prediction: pred_taken_o = counter MSB at the lookup index.
- Index: pc_idx = if_pc_i[IDX_BITS+1:2].
  - USE_GSHARE=1: index = pc_idx XOR zero-extended spec_ghr.
  - USE_GSHARE=0: index = pc_idx.
- FSM has two states: INIT and RUN.
- On rst assertion (asynchronous):
  - State goes to INIT; init counter = 0.
  - spec_ghr = 0; arch_ghr = 0.
  - ready_o = 0.
- INIT state:
  - Each cycle, write WNT to entry[init counter], then increment the counter.
  - After the last entry (2**IDX_BITS cycles total), go to RUN; ready_o = 1 from the next cycle.
  - pred_taken_o = 0; pred_idx_o = computed index.
  - ex_* and if_valid_i are ignored; the GHRs do not change.
- RUN state, training (when ex_valid_i):
  - ex_taken_i=1: entry[ex_idx_i] increments, saturating at MAX.
  - ex_taken_i=0: entry[ex_idx_i] decrements, saturating at 0.
  - Update is visible on the cycle after the clock edge.
- RUN state, history:
  - if_valid_i: spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_taken_o}.
  - ex_valid_i: arch_ghr <= {arch_ghr[GHR_BITS-2:0], ex_taken_i}.
  - ex_valid_i && ex_mispredict_i: spec_ghr <= {arch_ghr[GHR_BITS-2:0], ex_taken_i}. This overrides a same-cycle fetch shift.
  - GHR_BITS=1 degenerates to a single bit holding the last outcome.
- Same-index read and write in one cycle: the prediction returns the pre-update (old) counter value; there is no bypass.
- Reset asserted mid-INIT or mid-RUN: the FSM restarts INIT from entry 0, and all table contents are re-initialised.
- Latency: prediction is 0 cycles (combinational); training takes 1 cycle; initialisation takes 2**IDX_BITS cycles.

Test Plan:
- Reset, then hold rst low: ready_o=0 for exactly 64 cycles, then 1. Every entry reads 1 (WNT), and pred_taken_o=0 for any PC.
- USE_GSHARE=0, pc=0x14 (idx 5): train taken x1 -> pred 1. Train taken x2 more -> counter saturates at 3. Train not-taken x1 -> counter 2, pred still 1. Train not-taken x1 -> pred 0.
- USE_GSHARE=1, spec_ghr=6'b000011, if_pc_i=0x14 -> pred_idx_o=6. Same PC with ghr=0 -> pred_idx_o=5.
- Three fetch lookups all predicting 1 (spec_ghr=6'b000111), arch_ghr=0, then ex_valid+mispredict with taken=0 in the same cycle as if_valid -> spec_ghr=0 and arch_ghr=0 next cycle.
- ex_valid taken on idx 9 while fetch looks up idx 9 with counter=1 -> pred_taken_o=0 that cycle, 1 the next.
- Assert rst at INIT cycle 30 after training entries in RUN -> ready_o drops immediately. Re-init takes the full 64 cycles, and previously trained entries read WNT afterwards.

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// Direction predictor: table of saturating counters indexed by PC (bimodal) or PC^GHR (gshare),
// with speculative/architected global history and mispredict recovery; self-initialising after reset.
module branch_predictor_gshare #(
  parameter int IDX_BITS   = 6,
  parameter int CTR_BITS   = 2,
  parameter int GHR_BITS   = 6,
  parameter int USE_GSHARE = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready_o,
  input  logic                if_valid_i,
  input  logic [31:0]         if_pc_i,
  output logic                pred_taken_o,
  output logic [IDX_BITS-1:0] pred_idx_o,
  input  logic                ex_valid_i,
  input  logic [IDX_BITS-1:0] ex_idx_i,
  input  logic                ex_taken_i,
  input  logic                ex_mispredict_i
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] MAX = '1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d;
  logic [GHR_BITS-1:0] arch_ghr_q, arch_ghr_d;
  logic [CTR_BITS-1:0] table_q [DEPTH];

  logic [IDX_BITS-1:0] pc_idx, ghr_ext, lookup_idx;
  logic [CTR_BITS-1:0] ex_ctr, ex_ctr_next;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{if_pc_i[31:IDX_BITS+2], if_pc_i[1:0]};

  // History is zero-extended into the index width; works for GHR_BITS == IDX_BITS too.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_BITS-1:0] = spec_ghr_q;
  end

  always_comb begin
    pc_idx       = if_pc_i[IDX_BITS+1:2];
    lookup_idx   = (USE_GSHARE != 0) ? (pc_idx ^ ghr_ext) : pc_idx;
    pred_idx_o   = lookup_idx;
    pred_taken_o = (state_q == RUN) && table_q[lookup_idx][CTR_BITS-1];
    ready_o      = (state_q == RUN);
  end

  always_comb begin
    ex_ctr = table_q[ex_idx_i];
    if (ex_taken_i) ex_ctr_next = (ex_ctr == MAX) ? ex_ctr : ex_ctr + 1'b1;
    else            ex_ctr_next = (ex_ctr == '0)  ? ex_ctr : ex_ctr - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      spec_ghr_q <= spec_ghr_d;
      arch_ghr_q <= arch_ghr_d;
    end
  end

  // Shift-then-patch bit 0 keeps the GHR_BITS == 1 case free of negative slices.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    spec_ghr_d = spec_ghr_q;
    arch_ghr_d = arch_ghr_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) state_d = RUN;
      end
      RUN: begin
        if (if_valid_i) begin
          spec_ghr_d    = spec_ghr_q << 1;
          spec_ghr_d[0] = pred_taken_o;
        end
        if (ex_valid_i) begin
          arch_ghr_d    = arch_ghr_q << 1;
          arch_ghr_d[0] = ex_taken_i;
          if (ex_mispredict_i) spec_ghr_d = arch_ghr_d;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Table needs no reset: INIT rewrites every entry before predictions are enabled.
  always_ff @(posedge clk) begin
    if (state_q == INIT)  table_q[init_cnt_q] <= WNT;
    else if (ex_valid_i)  table_q[ex_idx_i]   <= ex_ctr_next;
  end

endmodule
